// File: rtl/btn_conditioner.sv
// Per-channel synchroniser, debouncer and press/release edge detector for active-low pushbuttons.
// Defining BTN_AUTOREPEAT_EN adds a held-button auto-repeat on btn_press.
module btn_conditioner #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [NUM_BTN-1:0] btn_raw_n,
  output logic [NUM_BTN-1:0] btn_level_n,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > CNT_MAX) begin : g_bad_debounce
    $error("btn_conditioner: DEBOUNCE_CYCLES out of range for CNT_W");
  end
`ifdef BTN_AUTOREPEAT_EN
  if (REPEAT_CYCLES < 1 || longint'(REPEAT_CYCLES) > CNT_MAX) begin : g_bad_repeat
    $error("btn_conditioner: REPEAT_CYCLES out of range for CNT_W");
  end
`else
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("btn_conditioner: REPEAT_CYCLES must be positive");
  end
`endif

  typedef enum logic [1:0] {ST_UP, ST_WAIT_DN, ST_DOWN, ST_WAIT_UP} state_t;

  // Per-channel FSM state; visible hierarchically as g_ch[i].ch_q for checkers.
  typedef struct packed {
    state_t           state;
    logic [CNT_W-1:0] cnt;
  } chan_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES);
  localparam bit               DIRECT  = (DEBOUNCE_CYCLES == 1);

  logic [NUM_BTN-1:0] s1, s2;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= btn_raw_n;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    chan_t ch_q, ch_d;
    logic  level_q, press_q, release_q;
    logic  level_d, press_d, release_d;
    logic  rep_fire;

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        ch_q.state <= ST_UP;
        ch_q.cnt   <= '0;
        level_q    <= 1'b1;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
      end else begin
        ch_q      <= ch_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // A reversal in a WAIT state returns to the stable state and drops the whole count.
    always_comb begin
      ch_d = ch_q;
      case (ch_q.state)
        ST_UP: begin
          if (!s2[i]) begin
            ch_d.state = DIRECT ? ST_DOWN : ST_WAIT_DN;
            ch_d.cnt   = DIRECT ? '0 : CNT_W'(1);
          end
        end
        ST_WAIT_DN: begin
          if (s2[i]) begin
            ch_d.state = ST_UP;
            ch_d.cnt   = '0;
          end else if (ch_q.cnt == DB_LAST) begin
            ch_d.state = ST_DOWN;
            ch_d.cnt   = '0;
          end else if (ch_q.cnt != '1) begin
            ch_d.cnt = ch_q.cnt + CNT_W'(1);
          end
        end
        ST_DOWN: begin
          if (s2[i]) begin
            ch_d.state = DIRECT ? ST_UP : ST_WAIT_UP;
            ch_d.cnt   = DIRECT ? '0 : CNT_W'(1);
          end
        end
        default: begin
          if (!s2[i]) begin
            ch_d.state = ST_DOWN;
            ch_d.cnt   = '0;
          end else if (ch_q.cnt == DB_LAST) begin
            ch_d.state = ST_UP;
            ch_d.cnt   = '0;
          end else if (ch_q.cnt != '1) begin
            ch_d.cnt = ch_q.cnt + CNT_W'(1);
          end
        end
      endcase
    end

    always_comb begin
      level_d   = (ch_d.state == ST_UP) || (ch_d.state == ST_WAIT_DN);
      press_d   = (ch_d.state == ST_DOWN) &&
                  (ch_q.state == ST_UP || ch_q.state == ST_WAIT_DN);
      release_d = (ch_d.state == ST_UP) &&
                  (ch_q.state == ST_DOWN || ch_q.state == ST_WAIT_UP);
      press_d   = press_d | rep_fire;
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rep_q, rep_d;

    // Counts cycles spent continuously in DOWN; cleared whenever DOWN is left.
    always_comb begin
      rep_d    = '0;
      rep_fire = 1'b0;
      if (ch_q.state == ST_DOWN && ch_d.state == ST_DOWN) begin
        if (rep_q == REP_LAST) rep_fire = 1'b1;
        else                   rep_d    = rep_q + CNT_W'(1);
      end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) rep_q <= '0;
      else          rep_q <= rep_d;
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign btn_level_n[i] = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios with literal expectations plus random
// bouncing stimulus checked every cycle against a run-length behavioural model.
module tb_btn_conditioner;
  localparam int NB   = 2;
  localparam int DB   = 4;
  localparam int CW   = 16;
  localparam int RC   = 8;
  localparam int NEED = (DB == 1) ? 1 : DB + 1;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  // clock / reset
  logic          Clk       = 1'b0;
  logic          Reset_n   = 1'b0;
  logic [NB-1:0] btn_raw_n = 2'b00;
  logic [NB-1:0] btn_level_n, btn_press, btn_release;

  always #5 Clk = ~Clk;

  btn_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (CW),
    .REPEAT_CYCLES  (RC)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .btn_raw_n  (btn_raw_n),
    .btn_level_n(btn_level_n),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  int n_cmp = 0;
  int n_err = 0;
  int npress[NB];
  int nrel[NB];
  logic [5:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // model: a change is accepted after NEED consecutive differing synchronised samples;
  // the synchronised sample seen at an edge is the raw value taken two edges earlier
  initial begin : model
    logic [NB-1:0] lvl, pr, rl, v;
    int run[NB];
    int held[NB];
    logic [NB-1:0] pipe_q[$];
    lvl = '1;
    for (int c = 0; c < NB; c++) begin run[c] = 0; held[c] = 0; end
    pipe_q.push_back(2'b11);
    pipe_q.push_back(2'b11);
    forever begin
      @(posedge Clk or negedge Reset_n);
      if (!Reset_n) begin
        lvl = '1;
        for (int c = 0; c < NB; c++) begin run[c] = 0; held[c] = 0; end
        pipe_q.delete();
        pipe_q.push_back(2'b11);
        pipe_q.push_back(2'b11);
        exp_q.delete();
        exp_q.push_back({2'b11, 2'b00, 2'b00});
      end else begin
        pipe_q.push_back(btn_raw_n);
        v  = pipe_q.pop_front();
        pr = '0;
        rl = '0;
        for (int c = 0; c < NB; c++) begin
          if (v[c] != lvl[c]) begin
            run[c]++;
            held[c] = 0;
            if (run[c] == NEED) begin
              lvl[c] = v[c];
              if (v[c] == 1'b0) pr[c] = 1'b1;
              else              rl[c] = 1'b1;
              run[c] = 0;
            end
          end else begin
            if (AR && lvl[c] == 1'b0) begin
              if (run[c] != 0) held[c] = 0;
              else begin
                held[c]++;
                if (held[c] == RC) begin
                  pr[c]   = 1'b1;
                  held[c] = 0;
                end
              end
            end
            run[c] = 0;
          end
        end
        exp_q.push_back({lvl, pr, rl});
      end
    end
  end

  // scoreboard: every cycle against the model
  initial begin : compare
    logic [5:0] e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("level", 8'(btn_level_n), 8'(e[5:4]));
        check("press", 8'(btn_press), 8'(e[3:2]));
        check("release", 8'(btn_release), 8'(e[1:0]));
        check("press_and_release", 8'(btn_press & btn_release), 8'd0);
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge Clk);
      #1;
      for (int c = 0; c < NB; c++) begin
        npress[c] += int'(btn_press[c]);
        nrel[c]   += int'(btn_release[c]);
      end
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NB; c++) begin
      npress[c] = 0;
      nrel[c]   = 0;
    end
  endtask

  initial begin : stim
    int seg[NB];
    clear_counts();

    // reset held with both buttons pressed
    tick(3);
    check("rst_level", 8'(btn_level_n), 8'h3);
    check("rst_press", 8'(btn_press), 8'h0);
    check("rst_release", 8'(btn_release), 8'h0);

    // held through reset: needs a full debounce after deassertion
    Reset_n = 1'b1;
    tick(6);
    check("held_rst_early", 8'(btn_level_n), 8'h3);
    tick(1);
    check("held_rst_level", 8'(btn_level_n), 8'h0);
    check("held_rst_press", 8'(btn_press), 8'h3);
    tick(1);
    check("held_rst_press_1cyc", 8'(btn_press), 8'h0);

    btn_raw_n = 2'b11;
    tick(6);
    check("rel_early", 8'(btn_release), 8'h0);
    tick(1);
    check("rel_strobe", 8'(btn_release), 8'h3);
    check("rel_level", 8'(btn_level_n), 8'h3);
    tick(3);

    // bounce ch0 every 2 cycles for 16 cycles, then hold pressed
    clear_counts();
    for (int i = 0; i < 8; i++) begin
      btn_raw_n[0] = (i % 2 == 1);
      tick(2);
    end
    btn_raw_n[0] = 1'b0;
    tick(6);
    check("bounce_press", 8'(npress[0]), 8'd0);
    check("bounce_release", 8'(nrel[0]), 8'd0);
    check("bounce_level", 8'(btn_level_n[0]), 8'd1);
    tick(1);
    check("bounce_accept", 8'(btn_press[0]), 8'd1);
    check("bounce_accept_lvl", 8'(btn_level_n[0]), 8'd0);
    btn_raw_n[0] = 1'b1;
    tick(7);
    check("ch0_release", 8'(btn_release[0]), 8'd1);
    tick(3);

    // channel independence: ch1 pressed two cycles after ch0
    btn_raw_n[0] = 1'b0;
    tick(2);
    btn_raw_n[1] = 1'b0;
    tick(4);
    check("indep_none", 8'(btn_press), 8'h0);
    tick(1);
    check("indep_ch0", 8'(btn_press), 8'h1);
    check("indep_lvl0", 8'(btn_level_n), 8'h2);
    tick(2);
    check("indep_ch1", 8'(btn_press), 8'h2);
    check("indep_lvl1", 8'(btn_level_n), 8'h0);
    btn_raw_n = 2'b11;
    tick(10);

    // async reset with ch0 DOWN and ch1 mid-WAIT_DN
    btn_raw_n[0] = 1'b0;
    tick(8);
    btn_raw_n[1] = 1'b0;
    tick(3);
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst_level", 8'(btn_level_n), 8'h3);
    check("async_rst_strobes", 8'({btn_press, btn_release}), 8'h0);
    tick(2);
    Reset_n = 1'b1;
    clear_counts();
    tick(6);
    check("post_rst_no_press", 8'(npress[0] + npress[1]), 8'd0);
    tick(1);
    check("post_rst_press", 8'(btn_press), 8'h3);
    btn_raw_n = 2'b11;
    tick(10);

    // auto-repeat on ch1
    btn_raw_n[1] = 1'b0;
    tick(7);
    check("ar_first", 8'(btn_press[1]), 8'd1);
    clear_counts();
    tick(7);
    check("ar_plus7", 8'(btn_press[1]), 8'd0);
    tick(1);
    check("ar_plus8", 8'(btn_press[1]), 8'(AR));
    tick(22);
    check("ar_count", 8'(npress[1] + 1), AR ? 8'd4 : 8'd1);
    check("ar_level", 8'(btn_level_n[1]), 8'd0);
    btn_raw_n[1] = 1'b1;
    tick(10);

    // random bouncing segments on both channels, one async reset in the middle
    for (int c = 0; c < NB; c++) seg[c] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < NB; c++) begin
        if (seg[c] == 0) begin
          btn_raw_n[c] = 1'($urandom_range(0, 1));
          seg[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 6);
        end
        seg[c]--;
      end
      if (cyc == 700) begin
        #2 Reset_n = 1'b0;
        tick(2);
        Reset_n = 1'b1;
      end
      tick(1);
    end
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
